// File: rtl/dual_core_mem_arbiter.sv
// Shared word memory with a registered round-robin arbiter for two cores.
// Optional ARB_STATS_EN adds saturating grant/wait counters per core.
module dual_core_mem_arbiter #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRequest0,
    input  logic        MemRead0,
    input  logic        MemWrite0,
    input  logic [31:0] MemAddress0,
    input  logic [31:0] MemWriteData0,
    output logic [31:0] MemReadData0,
    output logic        MemGrant0,
    input  logic        MemRequest1,
    input  logic        MemRead1,
    input  logic        MemWrite1,
    input  logic [31:0] MemAddress1,
    input  logic [31:0] MemWriteData1,
    output logic [31:0] MemReadData1,
    output logic        MemGrant1
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] GrantCnt0,
    output logic [31:0] GrantCnt1,
    output logic [31:0] WaitCnt0,
    output logic [31:0] WaitCnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              last_r;
    logic [31:0]       mem_r [DEPTH];
    logic [IDX_W-1:0]  idx0_s;
    logic [IDX_W-1:0]  idx1_s;
    logic              unused_s;

    // Only the word-index bits select a location; higher bits wrap.
    assign idx0_s = MemAddress0[IDX_W+1:2];
    assign idx1_s = MemAddress1[IDX_W+1:2];

    assign unused_s = ^{MemRead0, MemRead1,
                        MemAddress0[31:IDX_W+2], MemAddress0[1:0],
                        MemAddress1[31:IDX_W+2], MemAddress1[1:0]};

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if (state_r == GNT0) begin
                last_r <= 1'b0;
            end else if (state_r == GNT1) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Next-state: the request of the core being served is masked.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (MemRequest0 && MemRequest1) begin
                    next_state_s = last_r ? GNT0 : GNT1;
                end else if (MemRequest0) begin
                    next_state_s = GNT0;
                end else if (MemRequest1) begin
                    next_state_s = GNT1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT0: begin
                if (MemRequest1) begin
                    next_state_s = GNT1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT1: begin
                if (MemRequest0) begin
                    next_state_s = GNT0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    assign MemGrant0 = (state_r == GNT0);
    assign MemGrant1 = (state_r == GNT1);

    // Store path; gated by the registered state so a reset mid-grant drops it.
    always_ff @(posedge clk) begin
        if ((state_r == GNT0) && MemWrite0) begin
            mem_r[idx0_s] <= MemWriteData0;
        end else if ((state_r == GNT1) && MemWrite1) begin
            mem_r[idx1_s] <= MemWriteData1;
        end
    end

    // Load path: combinational, zero while the core is not granted.
    always_comb begin
        MemReadData0 = 32'd0;
        MemReadData1 = 32'd0;
        if (state_r == GNT0) begin
            MemReadData0 = mem_r[idx0_s];
        end else begin
            MemReadData0 = 32'd0;
        end
        if (state_r == GNT1) begin
            MemReadData1 = mem_r[idx1_s];
        end else begin
            MemReadData1 = 32'd0;
        end
    end

`ifdef ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        if (en && (value != 32'hFFFF_FFFF)) begin
            sat_inc = value + 32'd1;
        end else begin
            sat_inc = value;
        end
    endfunction

    // Saturating grant and wait counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            GrantCnt0 <= 32'd0;
            GrantCnt1 <= 32'd0;
            WaitCnt0  <= 32'd0;
            WaitCnt1  <= 32'd0;
        end else begin
            GrantCnt0 <= sat_inc(GrantCnt0, state_r == GNT0);
            GrantCnt1 <= sat_inc(GrantCnt1, state_r == GNT1);
            WaitCnt0  <= sat_inc(WaitCnt0, MemRequest0 && (state_r != GNT0));
            WaitCnt1  <= sat_inc(WaitCnt1, MemRequest1 && (state_r != GNT1));
        end
    end
`endif

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Randomized and directed bench for dual_core_mem_arbiter against a
// behavioural arbitration/memory model.
module tb_dual_core_mem_arbiter;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRequest0 = 1'b0, MemRead0 = 1'b0, MemWrite0 = 1'b0;
    logic [31:0] MemAddress0 = 32'd0, MemWriteData0 = 32'd0;
    logic [31:0] MemReadData0;
    logic        MemGrant0;
    logic        MemRequest1 = 1'b0, MemRead1 = 1'b0, MemWrite1 = 1'b0;
    logic [31:0] MemAddress1 = 32'd0, MemWriteData1 = 32'd0;
    logic [31:0] MemReadData1;
    logic        MemGrant1;
`ifdef ARB_STATS_EN
    logic [31:0] GrantCnt0, GrantCnt1, WaitCnt0, WaitCnt1;
`endif

    dual_core_mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .MemRequest0(MemRequest0), .MemRead0(MemRead0), .MemWrite0(MemWrite0),
        .MemAddress0(MemAddress0), .MemWriteData0(MemWriteData0),
        .MemReadData0(MemReadData0), .MemGrant0(MemGrant0),
        .MemRequest1(MemRequest1), .MemRead1(MemRead1), .MemWrite1(MemWrite1),
        .MemAddress1(MemAddress1), .MemWriteData1(MemWriteData1),
        .MemReadData1(MemReadData1), .MemGrant1(MemGrant1)
`ifdef ARB_STATS_EN
        ,
        .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1),
        .WaitCnt0(WaitCnt0), .WaitCnt1(WaitCnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks_r = 0;
    int errors_r = 0;

    // Model: which core (if any) holds the grant this cycle, the pointer, memory.
    int          m_gnt = -1;
    int          m_last = 1;
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [DEPTH];
    longint      m_gcnt [2];
    longint      m_wcnt [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr / 32'd4) % DEPTH);
    endfunction

    task automatic model_reset();
        m_gnt = -1;
        m_last = 1;
        for (int c = 0; c < 2; c++) begin
            m_gcnt[c] = 0;
            m_wcnt[c] = 0;
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input bit q[2], input bit w[2], input int ix[2], input logic [31:0] d[2]);
        bit elig[2];
        int base;
        for (int c = 0; c < 2; c++) begin
            if (m_gnt == c) m_gcnt[c]++;
            if (q[c] && m_gnt != c) m_wcnt[c]++;
            if (m_gnt == c && w[c]) begin
                m_mem[ix[c]] = d[c];
                m_valid[ix[c]] = 1'b1;
            end
            elig[c] = q[c] && (m_gnt != c);
        end
        base = (m_gnt >= 0) ? m_gnt : m_last;
        m_last = base;
        if (elig[0] && elig[1]) m_gnt = 1 - base;
        else if (elig[0]) m_gnt = 0;
        else if (elig[1]) m_gnt = 1;
        else m_gnt = -1;
    endtask

    task automatic check_outputs(input int ix0, input int ix1);
        check_eq("grant0", {31'd0, MemGrant0}, {31'd0, m_gnt == 0});
        check_eq("grant1", {31'd0, MemGrant1}, {31'd0, m_gnt == 1});
        if (m_gnt != 0) check_eq("rdata0_zero", MemReadData0, 32'd0);
        else if (m_valid[ix0]) check_eq("rdata0", MemReadData0, m_mem[ix0]);
        if (m_gnt != 1) check_eq("rdata1_zero", MemReadData1, 32'd0);
        else if (m_valid[ix1]) check_eq("rdata1", MemReadData1, m_mem[ix1]);
`ifdef ARB_STATS_EN
        check_eq("gcnt0", GrantCnt0, 32'(m_gcnt[0]));
        check_eq("gcnt1", GrantCnt1, 32'(m_gcnt[1]));
        check_eq("wcnt0", WaitCnt0, 32'(m_wcnt[0]));
        check_eq("wcnt1", WaitCnt1, 32'(m_wcnt[1]));
`endif
    endtask

    // One cycle: drive at the falling edge, check, then model the next rising edge.
    task automatic step(input bit rs,
                        input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                        input bit mid_rst);
        bit          q[2];
        bit          w[2];
        int          ix[2];
        logic [31:0] d[2];
        @(negedge clk);
        rst = rs;
        MemRequest0 = q0; MemWrite0 = w0; MemRead0 = q0 & ~w0;
        MemAddress0 = a0; MemWriteData0 = d0;
        MemRequest1 = q1; MemWrite1 = w1; MemRead1 = q1 & ~w1;
        MemAddress1 = a1; MemWriteData1 = d1;
        q[0] = q0; q[1] = q1; w[0] = w0; w[1] = w1;
        ix[0] = word_idx(a0); ix[1] = word_idx(a1);
        d[0] = d0; d[1] = d1;
        if (!rs) model_reset();
        #1;
        check_outputs(ix[0], ix[1]);
        if (mid_rst) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_eq("rst_async_grant1", {31'd0, MemGrant1}, 32'd0);
            check_eq("rst_async_rdata1", MemReadData1, 32'd0);
            check_outputs(ix[0], ix[1]);
        end else if (rs) begin
            model_edge(q, w, ix, d);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    logic [31:0] ra0, ra1;
    bit          prev_g0;

    initial begin
        model_reset();
        // Reset held with both cores requesting.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        // Tie after reset: core0 first, then core1.
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        check_eq("tie_first_core0", {31'd0, MemGrant0}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        check_eq("tie_then_core1", {31'd0, MemGrant1}, 32'd1);
        idle();
        // Next tie goes to core0 again.
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        check_eq("tie_again_core0", {31'd0, MemGrant0}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        idle();
        // Core0 store then load at 0x10.
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("store_wait", {31'd0, MemGrant0}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("store_grant", {31'd0, MemGrant0}, 32'd1);
        idle();
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("load_deadbeef", MemReadData0, 32'hDEADBEEF);
        idle();
        // Wrap: core1 stores above DEPTH*4, core0 reads the aliased word.
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, DEPTH * 4 + 8, 32'h1234, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, DEPTH * 4 + 8, 32'h1234, 1'b0);
        idle();
        step(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("wrap_load", MemReadData0, 32'h1234);
        idle();
        // Both held high: grants must alternate every cycle.
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
        prev_g0 = MemGrant0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
            check_eq("alternate", {31'd0, MemGrant0}, {31'd0, ~prev_g0});
            prev_g0 = MemGrant0;
        end
        idle();
        idle();
        // Reset in a GNT1 store cycle must lose the store.
        step(1'b1, 1'b1, 1'b0, 32'h20, 32'h1111_2222, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h20, 32'h1111_2222, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h20, 32'hA5A5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h20, 32'hA5A5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle();
        step(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("rst_store_lost", MemReadData0, 32'h1111_2222);
        idle();
        // Random traffic, including writes outside grant cycles and aliased addresses.
        for (int i = 0; i < 1500; i++) begin
            ra0 = ($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * DEPTH * 4) + $urandom_range(0, 3);
            ra1 = ($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * DEPTH * 4) + $urandom_range(0, 3);
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, ra0, $urandom,
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, ra1, $urandom,
                 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
